two_channel_request_issuer: RTL and testbench

- Requester-side counterpart of the two-request round-robin arbiter.
- Buffers payloads from two independent producers in per-channel FIFOs and drives one request line per non-empty channel.
- Accepts one-hot grants back from the arbiter, pops the granted head, and emits it on a single registered output stream tagged with its source channel.
- Also checks that the grants it receives obey the protocol.

---
 rtl/two_channel_request_issuer.sv | 97 +++++++++
 tb/tb_two_channel_request_issuer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/two_channel_request_issuer.sv
// two_channel_request_issuer: buffers two producer streams, requests arbitration, issues granted heads
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   push_valid/push_data0/1  per-channel write strobes and payloads
//   push_ready               per-channel not-full
//   requests                 per-channel not-empty, driven from the count registers only
//   grants                   one-hot grant from the arbiter, same cycle as requests
//   out_valid/out_data/out_src  registered issued payload and its source channel
//   grant_err                sticky flag for an illegal grant
//   err_count                saturating illegal-grant counter, present only with REQUEST_ISSUER_ERR_COUNT_EN
module two_channel_request_issuer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push_valid,
  input  logic [WIDTH-1:0] push_data0,
  input  logic [WIDTH-1:0] push_data1,
  output logic [1:0]       push_ready,
  output logic [1:0]       requests,
  input  logic [1:0]       grants,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             grant_err
`ifdef REQUEST_ISSUER_ERR_COUNT_EN
  ,
  output logic [7:0]       err_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [AW-1:0] rd_q [2];
  logic [AW-1:0] wr_q [2];
  logic [CW-1:0] cnt_q [2];
  logic [WIDTH-1:0] din [2];
  logic [1:0] push, pop;
  logic illegal;
  logic out_valid_q, out_valid_d, out_src_q, out_src_d, grant_err_q, grant_err_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  assign din[0] = push_data0;
  assign din[1] = push_data1;
  assign requests = {cnt_q[1] != '0, cnt_q[0] != '0};
  // full is judged on pre-pop state, so a push to a full channel is refused even when it pops
  assign push_ready = {cnt_q[1] != CW'(DEPTH), cnt_q[0] != CW'(DEPTH)};
  assign illegal = (&grants) | (|(grants & ~requests));
  assign push = rst ? 2'b00 : push_valid & push_ready;
  // an illegal grant suppresses every pop, leaving both FIFOs untouched
  assign pop = illegal ? 2'b00 : grants & requests;
  always_comb begin
    out_valid_d = |pop;
    out_src_d   = |pop ? pop[1] : out_src_q;
    out_data_d  = |pop ? mem_q[pop[1]][rd_q[pop[1]]] : out_data_q;
    grant_err_d = grant_err_q | illegal;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= din[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + AW'(1);
        if (pop[i]) rd_q[i] <= rd_q[i] + AW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      grant_err_q <= grant_err_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign grant_err = grant_err_q;
`ifdef REQUEST_ISSUER_ERR_COUNT_EN
  logic [7:0] err_count_q;
  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else if (illegal && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
  end
  assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_two_channel_request_issuer.sv
// tb_two_channel_request_issuer: scoreboarded directed bench for two_channel_request_issuer
module tb_two_channel_request_issuer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] push_valid = '0;
  logic [7:0] push_data0 = '0;
  logic [7:0] push_data1 = '0;
  logic [1:0] push_ready, requests;
  logic [1:0] grants = '0;
  logic out_valid, out_src, grant_err;
  logic [7:0] out_data;
`ifdef REQUEST_ISSUER_ERR_COUNT_EN
  logic [7:0] err_count;
`endif
  int checks = 0;
  int failures = 0;
  logic [8:0] sb [$];

  two_channel_request_issuer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_data0(push_data0),
    .push_data1(push_data1), .push_ready(push_ready), .requests(requests),
    .grants(grants), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .grant_err(grant_err)
`ifdef REQUEST_ISSUER_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic expect_out(input logic src, input logic [7:0] d);
    sb.push_back({src, d});
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out got src=%0d data=%0h exp=no beat", out_src, out_data);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({out_src, out_data} !== e) begin
          failures++;
          $display("FAIL out_beat got src=%0d data=%0h exp src=%0d data=%0h", out_src, out_data, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("rst_requests", 32'(requests), 32'h0);
    chk("rst_push_ready", 32'(push_ready), 32'h3);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_grant_err", 32'(grant_err), 32'h0);
    push_valid = 2'b01; push_data0 = 8'hA1;
    chk("single_req_same_cycle", 32'(requests), 32'h0);
    tick;
    chk("single_req_next_cycle", 32'(requests), 32'h1);
    push_data0 = 8'hA2;
    tick;
    push_valid = 2'b00;
    grants = 2'b01; expect_out(1'b0, 8'hA1);
    tick;
    expect_out(1'b0, 8'hA2);
    tick;
    grants = 2'b00;
    chk("single_req_drained", 32'(requests), 32'h0);
    tick;
    push_valid = 2'b11; push_data0 = 8'h10; push_data1 = 8'h20;
    tick;
    push_data0 = 8'h11; push_data1 = 8'h21;
    tick;
    push_valid = 2'b00;
    chk("alt_requests", 32'(requests), 32'h3);
    grants = 2'b01; expect_out(1'b0, 8'h10); tick;
    grants = 2'b10; expect_out(1'b1, 8'h20); tick;
    grants = 2'b01; expect_out(1'b0, 8'h11); tick;
    grants = 2'b10; expect_out(1'b1, 8'h21); tick;
    grants = 2'b00;
    chk("alt_drained", 32'(requests), 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("full_push_ready", 32'(push_ready[0]), (i < 4) ? 32'h1 : 32'h0);
      push_valid = 2'b01; push_data0 = 8'h30 + 8'(i);
      tick;
    end
    push_data0 = 8'h3F; grants = 2'b01; expect_out(1'b0, 8'h30);
    chk("full_refuse_ready", 32'(push_ready[0]), 32'h0);
    tick;
    for (int k = 0; k < 8; k++) begin
      chk("wrap_push_ready", 32'(push_ready[0]), 32'h1);
      chk("wrap_requests", 32'(requests), 32'h1);
      push_data0 = 8'h40 + 8'(k);
      expect_out(1'b0, (k < 3) ? 8'h31 + 8'(k) : 8'h40 + 8'(k - 3));
      tick;
    end
    push_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      expect_out(1'b0, 8'h45 + 8'(k));
      tick;
    end
    grants = 2'b00;
    chk("wrap_drained", 32'(requests), 32'h0);
    push_valid = 2'b01; push_data0 = 8'h50; tick;
    push_data0 = 8'h51; tick;
    push_valid = 2'b00;
    chk("err_before", 32'(grant_err), 32'h0);
    grants = 2'b10; tick;
    chk("err_after_bad_grant", 32'(grant_err), 32'h1);
    grants = 2'b11; tick;
    grants = 2'b00;
    chk("err_sticky", 32'(grant_err), 32'h1);
    chk("err_ch0_intact", 32'(requests), 32'h1);
`ifdef REQUEST_ISSUER_ERR_COUNT_EN
    chk("err_count", 32'(err_count), 32'h2);
`endif
    tick;
    chk("err_still_sticky", 32'(grant_err), 32'h1);
    grants = 2'b01; expect_out(1'b0, 8'h50); tick;
    expect_out(1'b0, 8'h51); tick;
    grants = 2'b00; tick;
    push_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      push_data0 = 8'h60 + 8'(i);
      tick;
    end
    push_valid = 2'b00;
    grants = 2'b01; rst = 1'b1;
    tick;
    rst = 1'b0; grants = 2'b00;
    chk("rst_mid_requests", 32'(requests), 32'h0);
    chk("rst_mid_push_ready", 32'(push_ready), 32'h3);
    chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_grant_err", 32'(grant_err), 32'h0);
    tick;
    push_valid = 2'b01; push_data0 = 8'h70; tick;
    push_valid = 2'b00;
    grants = 2'b01; expect_out(1'b0, 8'h70); tick;
    grants = 2'b00;
    chk("post_rst_drained", 32'(requests), 32'h0);
    tick;
    tick;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
